// File: rtl/pong_game_sequencer.sv
// Match-level sequencer for the pong datapath: attract, serve delay, play,
// point pause, game over and pause; owns the scores, serve side and winner.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_frame_tick,
  input  logic               i_start_btn,
  input  logic               i_pause_btn,
  input  logic               i_miss_l,
  input  logic               i_miss_r,
  output logic               o_run,
  output logic               o_serve_req,
  output logic               o_serve_side,
  output logic [SCORE_W-1:0] o_score_l,
  output logic [SCORE_W-1:0] o_score_r,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_POINT   = 3'd3,
    ST_OVER    = 3'd4,
    ST_PAUSE   = 3'd5
  } state_t;

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t             r_state;
  state_t             r_saved;
  logic [7:0]         r_fcnt;
  logic               r_run;
  logic               r_serve_req;
  logic               r_serve_side;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic               r_winner;
  // [0],[1] synchronize; [2] is the previous synchronized level for edge detect
  logic [2:0]         r_start_s;
  logic [2:0]         r_pause_s;

  logic               w_start_edge;
  logic               w_pause_edge;
  logic [SCORE_W-1:0] w_score_l_inc;
  logic [SCORE_W-1:0] w_score_r_inc;

  assign w_start_edge  = r_start_s[1] & ~r_start_s[2];
  assign w_pause_edge  = r_pause_s[1] & ~r_pause_s[2];
  assign w_score_l_inc = r_score_l + SCORE_W'(1);
  assign w_score_r_inc = r_score_r + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ATTRACT;
      r_saved      <= ST_SERVE;
      r_fcnt       <= '0;
      r_run        <= 1'b0;
      r_serve_req  <= 1'b0;
      r_serve_side <= 1'b0;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_winner     <= 1'b0;
      r_start_s    <= '0;
      r_pause_s    <= '0;
    end else begin
      r_start_s   <= {r_start_s[1:0], i_start_btn};
      r_pause_s   <= {r_pause_s[1:0], i_pause_btn};
      r_serve_req <= 1'b0;
      case (r_state)
        ST_ATTRACT, ST_OVER: begin
          if (w_start_edge) begin
            r_state      <= ST_SERVE;
            r_fcnt       <= '0;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_serve_side <= 1'b0;
            r_winner     <= 1'b0;
          end else if (i_frame_tick) begin
            r_fcnt <= r_fcnt + 8'd1;
          end
        end
        ST_SERVE: begin
          if (w_pause_edge) begin
            r_saved <= ST_SERVE;
            r_state <= ST_PAUSE;
          end else if (i_frame_tick) begin
            if (r_fcnt == SERVE_LAST) begin
              r_state     <= ST_PLAY;
              r_run       <= 1'b1;
              r_serve_req <= 1'b1;
              r_fcnt      <= '0;
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          // miss_l wins when both sides report a miss in the same cycle
          if (i_miss_l) begin
            r_score_r    <= w_score_r_inc;
            r_serve_side <= 1'b1;
            r_run        <= 1'b0;
            r_fcnt       <= '0;
            if (w_score_r_inc == WIN) begin
              r_state  <= ST_OVER;
              r_winner <= 1'b1;
            end else begin
              r_state <= ST_POINT;
            end
          end else if (i_miss_r) begin
            r_score_l    <= w_score_l_inc;
            r_serve_side <= 1'b0;
            r_run        <= 1'b0;
            r_fcnt       <= '0;
            if (w_score_l_inc == WIN) begin
              r_state  <= ST_OVER;
              r_winner <= 1'b0;
            end else begin
              r_state <= ST_POINT;
            end
          end else if (w_pause_edge) begin
            r_saved <= ST_PLAY;
            r_state <= ST_PAUSE;
            r_run   <= 1'b0;
          end else if (i_frame_tick) begin
            r_fcnt <= r_fcnt + 8'd1;
          end
        end
        ST_POINT: begin
          if (i_frame_tick) begin
            if (r_fcnt == POINT_LAST) begin
              r_state <= ST_SERVE;
              r_fcnt  <= '0;
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
        end
        ST_PAUSE: begin
          // fcnt is left untouched so the interrupted countdown resumes
          if (w_pause_edge) begin
            r_state <= r_saved;
            r_run   <= (r_saved == ST_PLAY);
          end
        end
        default: begin
          r_state <= ST_ATTRACT;
          r_run   <= 1'b0;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  assign o_run        = r_run;
  assign o_serve_req  = r_serve_req;
  assign o_serve_side = r_serve_side;
  assign o_score_l    = r_score_l;
  assign o_score_r    = r_score_r;
  assign o_winner     = r_winner;
  assign o_state      = r_state;

endmodule
